// File: rtl/rv_skid_reg_if.sv
// Valid/ready handshake bundle for rv_skid_reg: upstream push side, downstream pop side,
// and the occupancy count. "slave" is the register's own view; "master" is its surroundings.
interface rv_skid_reg_if #(
    parameter int BW_DATA = 32
);
    logic               i_sb_valid;
    logic               o_sb_ready;
    logic [BW_DATA-1:0] i_sb_data;
    logic               o_sb_valid;
    logic               i_sb_ready;
    logic [BW_DATA-1:0] o_sb_data;
    logic [1:0]         o_sb_cnt;

    modport slave (
        input  i_sb_valid,
        input  i_sb_data,
        input  i_sb_ready,
        output o_sb_ready,
        output o_sb_valid,
        output o_sb_data,
        output o_sb_cnt
    );

    modport master (
        output i_sb_valid,
        output i_sb_data,
        output i_sb_ready,
        input  o_sb_ready,
        input  o_sb_valid,
        input  o_sb_data,
        input  o_sb_cnt
    );
endinterface

// File: rtl/rv_skid_reg.sv
// Elastic pipeline register: a main register feeding the outputs plus a one-entry skid
// register, so upstream ready comes from a flop and never sees downstream ready.
module rv_skid_reg #(
    parameter int                 BW_DATA  = 32,
    parameter logic [BW_DATA-1:0] INIT_VAL = '0
) (
    input  logic            i_sb_clk,
    input  logic            i_sb_rst,
    input  logic            i_sb_flush,
    rv_skid_reg_if.slave    sb
);
    // Occupancy encoded as {main_v, skid_v}; 2'b01 is never entered.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic               main_v_reg, main_v_next;
    logic               skid_v_reg, skid_v_next;
    logic [BW_DATA-1:0] main_d_reg, main_d_next;
    logic [BW_DATA-1:0] skid_d_reg, skid_d_next;
    logic               in_fire;
    logic               out_fire;

    assign sb.o_sb_ready = ~skid_v_reg & ~i_sb_rst;
    assign sb.o_sb_valid = main_v_reg;
    assign sb.o_sb_data  = main_d_reg;
    assign sb.o_sb_cnt   = {1'b0, main_v_reg} + {1'b0, skid_v_reg};

    assign in_fire  = sb.i_sb_valid & sb.o_sb_ready;
    assign out_fire = main_v_reg & sb.i_sb_ready;

    always_comb begin
        main_v_next = main_v_reg;
        skid_v_next = skid_v_reg;
        main_d_next = main_d_reg;
        skid_d_next = skid_d_reg;
        if (i_sb_flush) begin
            // Data registers are left alone; only the valid bits are cleared.
            main_v_next = 1'b0;
            skid_v_next = 1'b0;
        end else begin
            case ({main_v_reg, skid_v_reg})
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_v_next = 1'b1;
                        main_d_next = sb.i_sb_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d_next = sb.i_sb_data;
                    end else if (in_fire) begin
                        skid_v_next = 1'b1;
                        skid_d_next = sb.i_sb_data;
                    end else if (out_fire) begin
                        main_v_next = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        skid_v_next = 1'b0;
                        main_d_next = skid_d_reg;
                    end
                end
                default: begin
                    main_v_next = 1'b0;
                    skid_v_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_sb_clk) begin
        if (i_sb_rst) begin
            main_v_reg <= 1'b0;
            skid_v_reg <= 1'b0;
            main_d_reg <= INIT_VAL;
            skid_d_reg <= INIT_VAL;
        end else begin
            main_v_reg <= main_v_next;
            skid_v_reg <= skid_v_next;
            main_d_reg <= main_d_next;
            skid_d_reg <= skid_d_next;
        end
    end
endmodule

// File: tb/tb_rv_skid_reg.sv
// Directed and random-backpressure checks of rv_skid_reg against hand-computed values
// and a queue scoreboard.
module tb_rv_skid_reg;
    localparam logic [31:0] INIT = 32'h13;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    rv_skid_reg_if #(.BW_DATA(32)) sb ();

    rv_skid_reg #(
        .BW_DATA (32),
        .INIT_VAL(INIT)
    ) dut (
        .i_sb_clk  (clk),
        .i_sb_rst  (rst),
        .i_sb_flush(flush),
        .sb        (sb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        sb.i_sb_valid = 1'b1;
        sb.i_sb_data  = d;
        tick();
    endtask

    logic [31:0] q[$];
    logic        v, r;
    logic [31:0] d;
    logic        exp_in, exp_out;

    initial begin
        rst = 1'b1; flush = 1'b0;
        sb.i_sb_valid = 1'b1; sb.i_sb_data = 32'hDEADBEEF; sb.i_sb_ready = 1'b0;

        // Reset held two cycles with a valid input pending
        tick();
        chk("rst_ready_low", {31'b0, sb.o_sb_ready}, 32'd0);
        chk("rst_valid_low", {31'b0, sb.o_sb_valid}, 32'd0);
        tick();
        rst = 1'b0; sb.i_sb_valid = 1'b0;
        #1;
        chk("rst_ready_after", {31'b0, sb.o_sb_ready}, 32'd1);
        chk("rst_valid_after", {31'b0, sb.o_sb_valid}, 32'd0);
        chk("rst_data_init",   sb.o_sb_data, INIT);
        chk("rst_cnt_zero",    {30'b0, sb.o_sb_cnt}, 32'd0);

        // Streaming at full throughput
        sb.i_sb_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(i);
            chk("str_valid", {31'b0, sb.o_sb_valid}, 32'd1);
            chk("str_data",  sb.o_sb_data, i);
            chk("str_cnt",   {30'b0, sb.o_sb_cnt}, 32'd1);
            chk("str_ready", {31'b0, sb.o_sb_ready}, 32'd1);
        end
        sb.i_sb_valid = 1'b0;
        tick();
        chk("str_drain_valid", {31'b0, sb.o_sb_valid}, 32'd0);
        chk("str_drain_cnt",   {30'b0, sb.o_sb_cnt}, 32'd0);

        // Stall into the skid register, then release
        sb.i_sb_ready = 1'b0;
        push(32'hA);
        chk("stl_cnt1",  {30'b0, sb.o_sb_cnt}, 32'd1);
        chk("stl_dataA", sb.o_sb_data, 32'hA);
        push(32'hB);
        chk("stl_cnt2",   {30'b0, sb.o_sb_cnt}, 32'd2);
        chk("stl_ready0", {31'b0, sb.o_sb_ready}, 32'd0);
        chk("stl_holdA",  sb.o_sb_data, 32'hA);
        push(32'hC);
        chk("stl_C_rejected", {30'b0, sb.o_sb_cnt}, 32'd2);
        chk("stl_holdA2",     sb.o_sb_data, 32'hA);
        sb.i_sb_ready = 1'b1;
        tick();
        chk("stl_outB",  sb.o_sb_data, 32'hB);
        chk("stl_vB",    {31'b0, sb.o_sb_valid}, 32'd1);
        chk("stl_cntB",  {30'b0, sb.o_sb_cnt}, 32'd1);
        tick();
        chk("stl_outC",  sb.o_sb_data, 32'hC);
        chk("stl_vC",    {31'b0, sb.o_sb_valid}, 32'd1);
        sb.i_sb_valid = 1'b0;
        tick();
        chk("stl_empty", {31'b0, sb.o_sb_valid}, 32'd0);

        // Flush from FULL with a simultaneous push that must be discarded
        sb.i_sb_ready = 1'b0;
        push(32'h11);
        push(32'h22);
        chk("fl_full", {30'b0, sb.o_sb_cnt}, 32'd2);
        flush = 1'b1; sb.i_sb_data = 32'h33;
        tick();
        flush = 1'b0; sb.i_sb_valid = 1'b0; sb.i_sb_ready = 1'b1;
        chk("fl_valid0", {31'b0, sb.o_sb_valid}, 32'd0);
        chk("fl_cnt0",   {30'b0, sb.o_sb_cnt}, 32'd0);
        chk("fl_ready1", {31'b0, sb.o_sb_ready}, 32'd1);
        tick();
        chk("fl_no33", {31'b0, sb.o_sb_valid}, 32'd0);
        push(32'h44);
        chk("fl_v44", {31'b0, sb.o_sb_valid}, 32'd1);
        chk("fl_d44", sb.o_sb_data, 32'h44);
        sb.i_sb_valid = 1'b0;
        tick();
        chk("fl_after44", {31'b0, sb.o_sb_valid}, 32'd0);

        // Reset while FULL and downstream ready
        sb.i_sb_ready = 1'b0;
        push(32'h55);
        push(32'h66);
        sb.i_sb_valid = 1'b0; sb.i_sb_ready = 1'b1; rst = 1'b1;
        tick();
        chk("mrst_valid", {31'b0, sb.o_sb_valid}, 32'd0);
        chk("mrst_cnt",   {30'b0, sb.o_sb_cnt}, 32'd0);
        chk("mrst_data",  sb.o_sb_data, INIT);
        chk("mrst_ready", {31'b0, sb.o_sb_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mrst_valid2", {31'b0, sb.o_sb_valid}, 32'd0);
        chk("mrst_data2",  sb.o_sb_data, INIT);
        chk("mrst_ready2", {31'b0, sb.o_sb_ready}, 32'd1);

        // Random backpressure against a queue model
        for (int n = 0; n < 1000; n++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            sb.i_sb_valid = v; sb.i_sb_ready = r; sb.i_sb_data = d;
            #1;
            chk("rnd_cnt",   {30'b0, sb.o_sb_cnt}, q.size());
            chk("rnd_ready", {31'b0, sb.o_sb_ready}, {31'b0, q.size() < 2});
            chk("rnd_valid", {31'b0, sb.o_sb_valid}, {31'b0, q.size() > 0});
            if (q.size() > 0) chk("rnd_data", sb.o_sb_data, q[0]);
            exp_in  = v && (q.size() < 2);
            exp_out = r && (q.size() > 0);
            if (exp_out) void'(q.pop_front());
            if (exp_in) q.push_back(d);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
